// File: rtl/hazard_pkg.sv
// Shared constants and state encoding for the hazard / MDU sequencing slice.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Counter width able to hold the longer of the two latencies.
    function automatic int cnt_width(input int mul_lat, input int div_lat);
        int m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// IDLE/RUN sequencer for the multi-cycle multiply/divide unit.
// A go strobe in IDLE loads LAT-1 and enters RUN; RUN lasts exactly LAT cycles,
// with done raised in the last one.
import hazard_pkg::*;

module mdu_seq #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic div,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(MUL_LAT, DIV_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    mdu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and down-counter registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on go, count down in RUN, leave RUN when the count hits 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                    cnt_d   = div ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: busy for the whole RUN, done in its final cycle.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state_q == ST_RUN) begin
            busy = 1'b1;
            done = (cnt_q == '0);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, HI/LO and back-to-back MDU
// interlock, taken-branch flush, and MDU start sequencing.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_mem_r,
    input  logic [4:0]  ex_w_addr,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_hilo_read,
    input  logic        ex_branch_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        mdu_go,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [15:0] stall_cycles
);

    logic lu, mh, stall, go, busy, done;
    logic [15:0] stall_cnt_q;

    // Hazard detection and start decision; a taken branch discards the ID
    // instruction, so it neither stalls nor starts the MDU.
    always_comb begin
        lu    = ex_mem_r && (ex_w_addr != REG_ZERO) &&
                ((id_use_rs && (id_rs == ex_w_addr)) ||
                 (id_use_rt && (id_rt == ex_w_addr)));
        mh    = busy && (id_hilo_read || id_mdu_start);
        stall = (lu || mh) && !ex_branch_taken;
        go    = id_mdu_start && !busy && !lu && !ex_branch_taken;
    end

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .div  (id_mdu_div),
        .busy (busy),
        .done (done)
    );

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    // Output drive; everything is held low while reset is asserted.
    always_comb begin
        stall_if     = !rst && stall;
        stall_id     = !rst && stall;
        bubble_ex    = !rst && (stall || ex_branch_taken);
        flush_id     = !rst && ex_branch_taken;
        mdu_go       = !rst && go;
        mdu_busy     = !rst && busy;
        mdu_done     = !rst && done;
        stall_cycles = rst ? 16'd0 : stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_w_addr;
    logic        id_use_rs, id_use_rt, ex_mem_r;
    logic        id_mdu_start, id_mdu_div, id_hilo_read, ex_branch_taken;
    logic        stall_if, stall_id, flush_id, bubble_ex;
    logic        mdu_go, mdu_busy, mdu_done;
    logic [15:0] stall_cycles;

    // Staged inputs, applied at the next falling edge by cycle().
    logic        s_rst;
    logic [4:0]  s_rs, s_rt, s_waddr;
    logic        s_use_rs, s_use_rt, s_mem_r, s_start, s_div, s_hilo, s_br;

    // Model state: MDU cycles still to run, and stalled-cycle total.
    int m_left;
    int m_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_mem_r(ex_mem_r), .ex_w_addr(ex_w_addr),
        .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div),
        .id_hilo_read(id_hilo_read), .ex_branch_taken(ex_branch_taken),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .mdu_go(mdu_go), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_rst = 0; s_rs = 0; s_rt = 0; s_waddr = 0; s_use_rs = 0; s_use_rt = 0;
        s_mem_r = 0; s_start = 0; s_div = 0; s_hilo = 0; s_br = 0;
    endtask

    // Apply staged inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit full_check = 1'b1);
        bit lu, run, stl, go;
        @(negedge clk);
        rst = s_rst; id_rs = s_rs; id_rt = s_rt; ex_w_addr = s_waddr;
        id_use_rs = s_use_rs; id_use_rt = s_use_rt; ex_mem_r = s_mem_r;
        id_mdu_start = s_start; id_mdu_div = s_div; id_hilo_read = s_hilo;
        ex_branch_taken = s_br;
        #1;
        if (s_rst) begin
            m_left = 0;
            m_cnt  = 0;
            chk("rst_outs", {stall_if, stall_id, flush_id, bubble_ex, mdu_go, mdu_busy, mdu_done}, 0);
            chk("rst_cnt", stall_cycles, 0);
            return;
        end
        lu  = s_mem_r && s_waddr != 0 && ((s_use_rs && s_rs == s_waddr) || (s_use_rt && s_rt == s_waddr));
        run = m_left > 0;
        stl = (lu || (run && (s_hilo || s_start))) && !s_br;
        go  = s_start && !run && !lu && !s_br;
        if (full_check) begin
            chk("stall_if", stall_if, stl);
            chk("stall_id", stall_id, stl);
            chk("bubble_ex", bubble_ex, stl || s_br);
            chk("flush_id", flush_id, s_br);
            chk("mdu_go", mdu_go, go);
            chk("mdu_busy", mdu_busy, run);
            chk("mdu_done", mdu_done, m_left == 1);
            chk("stall_cycles", stall_cycles, m_cnt);
        end
        if (go)       m_left = s_div ? DIV_LAT : MUL_LAT;
        else if (run) m_left--;
        if (stl && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        m_left = 0;
        m_cnt  = 0;
        idle_inputs();
        s_rst = 1;
        cycle();
        cycle();

        // Directed load-use, then the same with $zero as destination.
        idle_inputs();
        s_mem_r = 1; s_waddr = 8; s_rs = 8; s_use_rs = 1;
        cycle();
        idle_inputs();
        cycle();
        chk("lu_count", stall_cycles, 1);
        s_mem_r = 1; s_waddr = 0; s_rs = 0; s_use_rs = 1;
        cycle();
        idle_inputs();

        // Multiply followed by mfhi, then div immediately followed by mult.
        s_start = 1; cycle();
        idle_inputs(); s_hilo = 1;
        repeat (5) cycle();
        idle_inputs(); s_start = 1; s_div = 1; cycle();
        s_div = 0;
        repeat (34) cycle();
        idle_inputs();
        repeat (6) cycle();

        // Branch together with load-use and MDU start in IDLE.
        s_br = 1; s_mem_r = 1; s_waddr = 3; s_rt = 3; s_use_rt = 1; s_start = 1;
        cycle();
        idle_inputs();

        // Reset on the 10th busy cycle of a divide.
        s_start = 1; s_div = 1; cycle();
        idle_inputs();
        repeat (9) cycle();
        chk("div_busy9", mdu_busy, 1);
        s_rst = 1; cycle();
        idle_inputs();
        repeat (40) cycle();

        // Random traffic with small register sets so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            s_rst    = ($urandom_range(0, 299) == 0);
            s_rs     = 5'($urandom_range(0, 3));
            s_rt     = 5'($urandom_range(0, 3));
            s_waddr  = 5'($urandom_range(0, 3));
            s_use_rs = 1'($urandom);
            s_use_rt = 1'($urandom);
            s_mem_r  = ($urandom_range(0, 3) == 0);
            s_start  = ($urandom_range(0, 5) == 0);
            s_div    = ($urandom_range(0, 3) == 0);
            s_hilo   = ($urandom_range(0, 5) == 0);
            s_br     = ($urandom_range(0, 7) == 0);
            cycle();
        end

        // Saturation: a held load-use stall pins the counter at 0xFFFF.
        idle_inputs(); s_rst = 1; cycle();
        idle_inputs();
        s_mem_r = 1; s_waddr = 5; s_rt = 5; s_use_rt = 1;
        for (int i = 0; i < 65540; i++) cycle(i > 65530);
        chk("sat_cnt", stall_cycles, 16'hFFFF);
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
